// File: rtl/alu_pkg.sv
// Shared ALU package: cntrl opcodes for alu_16 and the multiplier sequencer state type.
package alu_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_NOR = 3'b101;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/alu_16.sv
// 16-bit ripple-carry ALU. Subtract/compare reuse the adder with inverted B and Cin=1.
import alu_pkg::*;

module alu_16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [2:0]  cntrl,
  output logic [15:0] result,
  output logic        carry_out,
  output logic        overflow,
  output logic        negative,
  output logic        zero
);

  logic        sub;
  logic [15:0] bx;
  logic [15:0] sum;
  logic [16:0] c;

  assign sub  = (cntrl == ALU_SUB) || (cntrl == ALU_SLT);
  assign bx   = sub ? ~b : b;
  assign c[0] = sub;

  // One full adder per bit; the carry ripples bit to bit.
  for (genvar i = 0; i < 16; i++) begin : g_fa
    assign sum[i]   = a[i] ^ bx[i] ^ c[i];
    assign c[i+1]   = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
  end

  assign carry_out = c[16];
  assign overflow  = c[16] ^ c[15];
  assign negative  = result[15];
  assign zero      = (result == 16'h0000);

  // Operation select.
  always_comb begin
    result = 16'h0000;
    case (cntrl)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_ADD: result = sum;
      ALU_SUB: result = sum;
      ALU_XOR: result = a ^ b;
      ALU_NOR: result = ~(a | b);
      ALU_SLT: result = {15'h0000, sum[15] ^ overflow};
      default: result = 16'h0000;
    endcase
  end

endmodule

// File: rtl/alu_seq_mul.sv
// Sequential unsigned 16x16->32 shift-add multiplier sharing one alu_16 as its adder.
// One shift-add step per clock; start/busy/done handshake.
// Optional: ALU_SEQ_MUL_EARLY_EXIT_EN stops as soon as the remaining multiplier bits are zero.
import alu_pkg::*;

module alu_seq_mul (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] product
);

  mul_state_e  state_q;
  logic [32:0] p_q;
  logic [3:0]  cnt_q;
  logic [15:0] mcand_q;
  logic [31:0] prod_q;

  logic [15:0] alu_b;
  logic [15:0] alu_res;
  logic        alu_cout;
  logic        alu_ovf, alu_neg, alu_zero;
  logic [32:0] p_nxt;
  logic        last;
  logic [31:0] prod_nxt;
  logic        accept;
  logic        unused_bits;

  // Add the multiplicand into the upper half only when the current multiplier bit is set.
  assign alu_b = p_q[0] ? mcand_q : 16'h0000;

  alu_16 u_alu (
    .a         (p_q[31:16]),
    .b         (alu_b),
    .cntrl     (ALU_ADD),
    .result    (alu_res),
    .carry_out (alu_cout),
    .overflow  (alu_ovf),
    .negative  (alu_neg),
    .zero      (alu_zero)
  );

  // Right shift of {carry, sum, lo}: consumed multiplier bit falls off the bottom.
  assign p_nxt = {1'b0, alu_cout, alu_res, p_q[15:1]};

`ifdef ALU_SEQ_MUL_EARLY_EXIT_EN
  // After step cnt, the low 15-cnt bits of P are still-unprocessed multiplier bits.
  // If they are all zero the remaining steps would only shift, so do that shift at once.
  logic [15:0] rem_mask;
  assign rem_mask = 16'h7fff >> cnt_q;
  assign last     = ((p_nxt[15:0] & rem_mask) == 16'h0000);
  assign prod_nxt = p_nxt[31:0] >> (4'd15 - cnt_q);
`else
  assign last     = (cnt_q == 4'd15);
  assign prod_nxt = p_nxt[31:0];
`endif

  assign unused_bits = ^{p_q[32], p_nxt[32], alu_ovf, alu_neg, alu_zero};

  assign accept  = start && (state_q != RUN);
  assign busy    = (state_q == RUN);
  assign done    = (state_q == DONE);
  assign product = prod_q;

  // FSM, step counter, partial product and result register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      p_q     <= '0;
      cnt_q   <= '0;
      mcand_q <= '0;
      prod_q  <= '0;
    end else begin
      case (state_q)
        RUN: begin
          p_q   <= p_nxt;
          cnt_q <= cnt_q + 4'd1;
          if (last) begin
            prod_q  <= prod_nxt;
            state_q <= DONE;
          end
        end
        default: begin
          if (accept) begin
            mcand_q <= a;
            p_q     <= {17'h0_0000, b};
            cnt_q   <= '0;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/alu_seq_mul.md
# alu_seq_mul

Multi-cycle unsigned 16x16→32 multiplier sequencer that time-shares one instance of the team's 16-bit ripple ALU (`alu_16`) as its adder. It runs one shift-add step per clock, driving the ALU's A/B/cntrl inputs and consuming its result and carry_out. It sits beside the CPU execute stage as the MUL unit, with a start/busy/done handshake. The configuration macro below adds an early-exit option.

## Interface
Parameters: none; width fixed at 16.
- clk  in  1  system clock, rising-edge
- reset  in  1  synchronous, active-high
- start  in  1  request; sampled in IDLE or DONE
- a  in  16  multiplicand, captured on accept
- b  in  16  multiplier, captured on accept
- busy  out  1  high while state is RUN
- done  out  1  one-cycle pulse; product valid
- product  out  32  result, held until the next accept

## Operation
- State encoding uses three states: IDLE, RUN, DONE.
- **Accept:** start=1 while in IDLE or DONE.
  - mcand_q is loaded with a.
  - P[32:0] is loaded with {1'b0, 16'h0000, b}.
  - cnt is loaded with 0.
  - The next state is RUN.
- start is ignored while in RUN (no queueing).
- **RUN step** (one per cycle):
  - The ALU is driven with A = P[31:16], B = P[0] ? mcand_q : 16'h0000, cntrl = ALU_ADD (3'b010, Cin=0).
  - P is updated to {1'b0, alu.carry_out, alu.result, P[15:1]}, a right shift of {carry, sum, lo}.
  - cnt is incremented.
- **RUN exit:** after the step with cnt==15 (16 steps), go to DONE.
  - product is loaded with the shifted P[31:0].
- **DONE:** done=1 for exactly one cycle.
  - Without an accept, the next state is IDLE.
  - An accept in DONE goes directly to RUN (back-to-back operation).
- **Arithmetic:** product = a*b, unsigned. No truncation or overflow is possible.
  - The ALU overflow, negative and zero outputs are unused.
- **Reset** (also mid-operation) forces the following on the next edge:
  - state=IDLE, P=0, cnt=0, mcand_q=0
  - product=0, busy=0, done=0
  - Any in-flight result is discarded.

## Timing
- Cycle 0: start=1 sampled in IDLE/DONE.
- Cycles 1–16: RUN, with busy=1.
- Cycle 17: DONE, with done=1 and product valid.
- Latency is 17 cycles from accept edge to done; throughput is one result per 17 cycles back-to-back.
- product updates only on the edge entering DONE and is stable otherwise.
- All outputs are registered. busy and done are decoded from the state register with no combinational path from start.
- The ALU carry chain (16 ripple stages) plus the P mux is the critical path, one ALU op per cycle.

## Configuration
- `ALU_SEQ_MUL_EARLY_EXIT_EN` defined:
  - At the end of every RUN step, if the remaining unprocessed multiplier bits (the low 15-cnt bits of the shifted P) are all zero, finish immediately.
  - product is loaded with the shifted P further right-shifted by (15-cnt), and the next state is DONE.
  - RUN length = index of the most significant 1 of b, plus 1.
  - b=0 takes 1 RUN cycle, giving a 2-cycle latency.
  - The result is identical to the non-early-exit result.
- Macro undefined: RUN is always exactly 16 cycles and no shifter logic is built.

## Structure
- Shared package `alu_pkg` holds:
  - the ALU cntrl constants (ALU_ADD=3'b010, ALU_SUB=3'b011, plus the others used by the core);
  - the state typedef `mul_state_e` {IDLE, RUN, DONE}.
- One sub-module, `alu_16`, instantiated once.
- FSM, counter, P register and output register live in the top module.

## Test plan
- a=3, b=5 → done pulse 17 cycles after accept, product=32'h0000000F, busy high for cycles 1–16.
- a=16'hFFFF, b=16'hFFFF → product=32'hFFFE0001, exercising ALU carry_out on every step.
- Accept a=16'h1234, b=16'h0010, then pulse start with a=b=16'hFFFF at cycle 5 → second request ignored; product=32'h00012340 at cycle 17.
- Accept 7×9; assert reset at cycle 8 → next cycle IDLE, busy=0, product=0, and no done pulse ever. A new 2×2 then yields 4.
- Back-to-back: start held high with 10×10 and then 16'h8000×2 → done at cycles 17 and 34, products 100 and 32'h00010000.
- With `ALU_SEQ_MUL_EARLY_EXIT_EN`:
  - a=16'hABCD, b=1 → done at cycle 2, product=32'h0000ABCD.
  - b=0 → done at cycle 2, product=0.
  - b=16'h8000 → done at cycle 17.
